// File: rtl/ic_result_if.sv
// Ray-intersection result collector bus.
// The in_* side carries per-triangle intersection results; the out_* side
// presents the closest-hit record of each completed ray.
// With IC_STATS_EN defined, ray_count and hit_count statistics are added.
interface ic_result_if #(
    parameter int IDX_W = 16
);
    logic             in_valid;
    logic             in_last;
    logic [31:0]      in_sid;
    logic             in_hit;
    logic [31:0]      in_t;
    logic [95:0]      in_point;
    logic [95:0]      in_norm;

    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_sid;
    logic             out_hit;
    logic [31:0]      out_t;
    logic [95:0]      out_point;
    logic [95:0]      out_norm;
    logic [IDX_W-1:0] out_tri_idx;
    logic             overflow;
`ifdef IC_STATS_EN
    logic [31:0]      ray_count;
    logic [31:0]      hit_count;
`endif

    // Collector side
    modport slave (
        input  in_valid, in_last, in_sid, in_hit, in_t, in_point, in_norm, out_ready,
        output out_valid, out_sid, out_hit, out_t, out_point, out_norm, out_tri_idx, overflow
`ifdef IC_STATS_EN
        , output ray_count, hit_count
`endif
    );

    // Producer / consumer side
    modport master (
        output in_valid, in_last, in_sid, in_hit, in_t, in_point, in_norm, out_ready,
        input  out_valid, out_sid, out_hit, out_t, out_point, out_norm, out_tri_idx, overflow
`ifdef IC_STATS_EN
        , input ray_count, hit_count
`endif
    );
endinterface

// File: rtl/ic_result_collector.sv
// Closest-hit collector: folds the per-triangle results of one ray into a
// single best record and queues completed rays in a small result FIFO.
// Optional feature macro IC_STATS_EN adds ray_count / hit_count outputs.
module ic_result_collector #(
    parameter int FIFO_DEPTH = 2,
    parameter int IDX_W      = 16
) (
    input  logic       clk,
    input  logic       rst,
    ic_result_if.slave bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(FIFO_DEPTH);

    typedef struct packed {
        logic [31:0]      sid;
        logic             hit;
        logic [31:0]      t;
        logic [95:0]      point;
        logic [95:0]      norm;
        logic [IDX_W-1:0] idx;
    } rec_t;

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t           state_reg;
    rec_t             best_reg;
    rec_t             best_next;
    logic [IDX_W-1:0] idx_reg;
    logic [IDX_W-1:0] cur_idx;
    logic             first;
    logic             qualifies;
    logic             better;

    rec_t             mem [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [PTR_W:0]   count_reg;
    logic             overflow_reg;
    logic             push;
    logic             pop;
    logic             full;
    logic             accept;
    rec_t             head;
    logic             head_valid;

    // Qualify the incoming hit and fold it into the running best; a new ray
    // starts from a cleared record so misses leave all data fields at zero.
    always_comb begin
        first     = (state_reg == IDLE);
        qualifies = bus.in_hit && !bus.in_t[31] && (bus.in_t != 32'd0) &&
                    (bus.in_t[30:23] != 8'hFF);
        cur_idx   = first ? '0 : idx_reg + {{(IDX_W-1){1'b0}}, 1'b1};
        better    = qualifies && (first || !best_reg.hit || (bus.in_t < best_reg.t));
        best_next = best_reg;
        if (first) begin
            best_next     = '0;
            best_next.sid = bus.in_sid;
        end
        if (better) begin
            best_next.hit   = 1'b1;
            best_next.t     = bus.in_t;
            best_next.point = bus.in_point;
            best_next.norm  = bus.in_norm;
            best_next.idx   = cur_idx;
        end
    end

    assign push   = bus.in_valid && bus.in_last;
    assign pop    = (count_reg != '0) && bus.out_ready;
    assign full   = (count_reg == DEPTH_C);
    assign accept = push && (!full || pop);

    // Ray FSM: tracks whether the next result opens a new ray and holds the best record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            best_reg  <= '0;
            idx_reg   <= '0;
        end else if (bus.in_valid) begin
            best_reg  <= best_next;
            idx_reg   <= cur_idx;
            state_reg <= bus.in_last ? IDLE : ACCUM;
        end
    end

    // Result storage; contents need no reset because the head is masked while empty.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_ptr_reg] <= best_next;
        end
    end

    // FIFO pointers, occupancy and sticky overflow on a dropped ray.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            overflow_reg <= 1'b0;
        end else begin
            if (accept) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            if (accept && !pop) begin
                count_reg <= count_reg + 1'b1;
            end else if (!accept && pop) begin
                count_reg <= count_reg - 1'b1;
            end
            if (push && !accept) begin
                overflow_reg <= 1'b1;
            end
        end
    end

    assign head_valid      = (count_reg != '0);
    assign head            = head_valid ? mem[rd_ptr_reg] : '0;
    assign bus.out_valid   = head_valid;
    assign bus.out_sid     = head.sid;
    assign bus.out_hit     = head.hit;
    assign bus.out_t       = head.t;
    assign bus.out_point   = head.point;
    assign bus.out_norm    = head.norm;
    assign bus.out_tri_idx = head.idx;
    assign bus.overflow    = overflow_reg;

`ifdef IC_STATS_EN
    logic [31:0] ray_count_reg;
    logic [31:0] hit_count_reg;

    // Completion statistics, counting dropped rays as well.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ray_count_reg <= '0;
            hit_count_reg <= '0;
        end else if (push) begin
            ray_count_reg <= ray_count_reg + 32'd1;
            if (best_next.hit) begin
                hit_count_reg <= hit_count_reg + 32'd1;
            end
        end
    end

    assign bus.ray_count = ray_count_reg;
    assign bus.hit_count = hit_count_reg;
`endif
endmodule

// File: tb/tb_ic_result_collector.sv
// Scoreboard bench for ic_result_collector: the stimulus side models each ray
// as a list of triangle results, picks the closest qualifying one, and queues
// the expected record; a negedge monitor checks every record the DUT hands out.
module tb_ic_result_collector;
    localparam int DEPTH = 2;
    localparam int IDX_W = 16;

    typedef struct packed {
        logic [31:0]      sid;
        logic             hit;
        logic [31:0]      t;
        logic [95:0]      point;
        logic [95:0]      norm;
        logic [IDX_W-1:0] idx;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ic_result_if #(.IDX_W(IDX_W)) bus ();

    ic_result_collector #(.FIFO_DEPTH(DEPTH), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   errors  = 0;
    int   checks  = 0;
    bit   started = 0;
    exp_t sb[$];
    int   mcount  = 0;
    bit   movf    = 0;

    bit          in_ray = 0;
    logic [31:0] r_sid;
    logic [31:0] r_t[$];
    bit          r_hit[$];
    logic [95:0] r_pt[$];
    logic [95:0] r_nm[$];

    task automatic chk(input string nm, input logic [299:0] act, input logic [299:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    function automatic bit qual(bit h, logic [31:0] t);
        return h && !t[31] && (t != 32'd0) && (t[30:23] != 8'hFF);
    endfunction

    // Closest qualifying triangle of the recorded ray; earliest wins a tie.
    function automatic exp_t ray_result();
        exp_t e = '0;
        int   best = -1;
        e.sid = r_sid;
        for (int i = 0; i < r_t.size(); i++) begin
            if (qual(r_hit[i], r_t[i]) && (best < 0 || r_t[i] < r_t[best])) best = i;
        end
        if (best >= 0) begin
            e.hit   = 1'b1;
            e.t     = r_t[best];
            e.point = r_pt[best];
            e.norm  = r_nm[best];
            e.idx   = IDX_W'(best);
        end
        return e;
    endfunction

    // Drive one cycle and advance the reference model on the committing edge.
    task automatic step(input bit v, input bit last, input logic [31:0] sid, input bit hit,
                        input logic [31:0] t, input bit rdy);
        logic [95:0] pt;
        logic [95:0] nm;
        bit pop;
        bit acc;
        pt = {$urandom, $urandom, $urandom};
        nm = {$urandom, $urandom, $urandom};
        bus.in_valid  = v;
        bus.in_last   = last;
        bus.in_sid    = sid;
        bus.in_hit    = hit;
        bus.in_t      = t;
        bus.in_point  = pt;
        bus.in_norm   = nm;
        bus.out_ready = rdy;
        @(posedge clk);
        pop = (mcount > 0) && rdy;
        acc = 0;
        if (v) begin
            if (!in_ray) begin
                r_sid = sid;
                r_t.delete(); r_hit.delete(); r_pt.delete(); r_nm.delete();
                in_ray = 1;
            end
            r_t.push_back(t); r_hit.push_back(hit); r_pt.push_back(pt); r_nm.push_back(nm);
            if (last) begin
                in_ray = 0;
                if (mcount < DEPTH || pop) begin
                    sb.push_back(ray_result());
                    acc = 1;
                end else begin
                    movf = 1;
                end
            end
        end
        mcount = mcount + (acc ? 1 : 0) - (pop ? 1 : 0);
        #1;
    endtask

    task automatic idle(input bit rdy);
        step(0, 0, 32'd0, 0, 32'd0, rdy);
    endtask

    task automatic drain();
        int guard = 0;
        while (mcount > 0 && guard < 50) begin
            idle(1);
            guard++;
        end
        chk("drain_timeout", 300'(mcount), 300'(0));
    endtask

    function automatic logic [31:0] pick_t();
        logic [31:0] r;
        r = $urandom;
        r[31] = 1'b0;
        case ($urandom_range(0, 8))
            0: return 32'h00000000;
            1: return 32'hBF800000;
            2: return 32'h7FC00000;
            3: return 32'h7F800000;
            4: return 32'h3F800000;
            5: return 32'h40000000;
            6: return 32'h40400000;
            default: return r;
        endcase
    endfunction

    function automatic exp_t dut_rec();
        return {bus.out_sid, bus.out_hit, bus.out_t, bus.out_point, bus.out_norm, bus.out_tri_idx};
    endfunction

    // Monitor: checks occupancy, sticky overflow and each record taken by the consumer.
    always @(negedge clk) begin
        if (started && !rst) begin
            chk("out_valid", 300'(bus.out_valid), 300'(sb.size() != 0));
            chk("overflow", 300'(bus.overflow), 300'(movf));
            if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
                chk("record", 300'(dut_rec()), 300'(sb.pop_front()));
            end else if (!bus.out_valid) begin
                chk("empty_data", 300'(dut_rec()), 300'(0));
            end
        end
    end

    initial begin
        bus.in_valid = 0; bus.in_last = 0; bus.in_sid = 0; bus.in_hit = 0;
        bus.in_t = 0; bus.in_point = 0; bus.in_norm = 0; bus.out_ready = 0;
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 300'({bus.out_valid, bus.overflow, dut_rec()}), 300'(0));
        rst = 0;
        started = 1;
        idle(0);

        // Single-triangle ray is visible one cycle later.
        step(1, 1, 32'd7, 1, 32'h40000000, 0);
        chk("single_valid", 300'(bus.out_valid), 300'(1));
        chk("single_sid", 300'(bus.out_sid), 300'(7));
        chk("single_t", 300'(bus.out_t), 300'(32'h40000000));
        chk("single_idx", 300'(bus.out_tri_idx), 300'(0));
        drain();

        // Tie keeps the earlier triangle.
        step(1, 0, 32'd9, 1, 32'h40400000, 0);
        step(1, 0, 32'd99, 1, 32'h3F800000, 0);
        step(1, 1, 32'd98, 1, 32'h3F800000, 0);
        chk("tie_t", 300'(bus.out_t), 300'(32'h3F800000));
        chk("tie_idx", 300'(bus.out_tri_idx), 300'(1));
        chk("tie_sid", 300'(bus.out_sid), 300'(9));
        drain();

        // Negative, zero and NaN distances never qualify.
        step(1, 0, 32'd11, 1, 32'hBF800000, 0);
        step(1, 0, 32'd11, 1, 32'h00000000, 0);
        step(1, 1, 32'd11, 1, 32'h7FC00000, 0);
        chk("disq_hit", 300'({bus.out_hit, bus.out_t, bus.out_tri_idx}), 300'(0));
        drain();

        // Overflow on a full FIFO, then push-while-full with a simultaneous pop.
        step(1, 1, 32'd21, 1, 32'h3F800000, 0);
        step(1, 1, 32'd22, 0, 32'h3F800000, 0);
        step(1, 1, 32'd23, 1, 32'h40000000, 0);
        chk("ovf_set", 300'(bus.overflow), 300'(1));
        chk("ovf_head", 300'(bus.out_sid), 300'(21));
        step(1, 1, 32'd24, 1, 32'h40400000, 1);
        chk("ovf_keep", 300'(bus.out_sid), 300'(22));
        drain();
        chk("ovf_sticky", 300'(bus.overflow), 300'(1));

        // Reset in the middle of a ray clears everything at once.
        step(1, 0, 32'd31, 1, 32'h40000000, 0);
        step(1, 0, 32'd31, 1, 32'h3F800000, 0);
        rst = 1;
        sb.delete(); mcount = 0; movf = 0; in_ray = 0;
        #1;
        chk("async_reset", 300'({bus.out_valid, bus.overflow, dut_rec()}), 300'(0));
        bus.in_valid = 0;
        @(posedge clk);
        #1;
        rst = 0;
        step(1, 1, 32'd41, 1, 32'h40400000, 0);
        chk("post_reset_sid", 300'(bus.out_sid), 300'(41));
        chk("post_reset_idx", 300'({bus.out_hit, bus.out_tri_idx}), 300'({1'b1, 16'd0}));
        drain();

        // Randomized rays with gaps and random consumer backpressure.
        for (int r = 0; r < 300; r++) begin
            int len = $urandom_range(1, 5);
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) idle($urandom_range(0, 1));
                step(1, k == len - 1, $urandom, $urandom_range(0, 3) != 0, pick_t(),
                     $urandom_range(0, 1));
            end
        end
        drain();
        idle(0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ic_result_collector.md
IC_RESULT_COLLECTOR -- requirements
Module: ic_result_collector

Interface
REQ-001 Parameter FIFO_DEPTH, default 2, output result FIFO entries; a power of two, 2 or more.
REQ-002 Parameter IDX_W, default 16, width of the triangle index counter.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, asynchronous and active-high.
REQ-005 in_valid  input  1  intersection result present this cycle; there is no backpressure, so every valid is accepted.
REQ-006 in_last  input  1  marks the last triangle result of the current ray.
REQ-007 in_sid  input  32  ray/shader id; captured on the first result of a ray.
REQ-008 in_hit  input  1  raw hit flag from the intersection pipeline.
REQ-009 in_t  input  32  IEEE-754 single-precision ray parameter t.
REQ-010 in_point  input  96  intersection point {x,y,z}, 3x32 float.
REQ-011 in_norm  input  96  unnormalized face normal, 3x32 float.
REQ-012 out_valid  output  1  FIFO head holds a completed ray result.
REQ-013 out_ready  input  1  consumer accepts the head when out_valid=1 and out_ready=1.
REQ-014 out_sid, out_t  output  32 each; out_point, out_norm  output  96 each  closest-hit data.
REQ-015 out_hit  output  1  at least one qualifying hit occurred for the ray.
REQ-016 out_tri_idx  output  IDX_W  zero-based index within the ray of the closest hit; 0 when out_hit=0.
REQ-017 overflow  output  1  sticky flag: a completed ray was dropped because the FIFO was full.

Function
REQ-018 Qualifying hit: in_hit=1, sign bit=0, in_t not equal to 0, and exponent not equal to 8'hFF (NaN and Inf are rejected).
REQ-019 Distance compare: treat qualifying t as unsigned 32-bit integers; a new hit replaces the best only when strictly smaller, so on a tie the earlier triangle wins.
REQ-020 State machine, IDLE:
  - in_valid with in_last=0 -> ACCUM;
  - in_valid with in_last=1 -> single-triangle ray, pushed directly; stay in IDLE.
REQ-021 State machine, ACCUM:
  - each in_valid increments the index counter and updates the best;
  - in_valid with in_last=1 -> push the ray result and return to IDLE.
REQ-022 On the first result of a ray: capture the sid, set the index counter to 0, and load the best from that result if it qualifies; otherwise clear best_hit.
REQ-023 Push timing: the result reflects every triangle up to and including the in_last triangle, and is visible at the FIFO head one cycle after that in_last cycle when the FIFO was empty.
REQ-024 The index counter wraps modulo 2^IDX_W with no error.
REQ-025 Push and pop in the same cycle are both performed; when full, a simultaneous pop frees space for the push, so there is no overflow.
REQ-026 Push while full with no pop: the new result is discarded, overflow is set, and the FIFO contents are unchanged.
REQ-027 When out_hit=0, out_t, out_point and out_norm are zero.
REQ-028 Outputs are driven directly from FIFO registers; no combinational path runs from in_* to out_*.

Reset
REQ-029 Assertion of rst, including mid-ray, immediately:
  - returns the FSM to IDLE;
  - empties the FIFO;
  - clears the best registers and the index counter;
  - drives out_valid, out_hit and overflow to 0;
  - drives every data output to 0.
REQ-030 overflow clears only on rst.

Configuration
REQ-031 Macro IC_STATS_EN: when defined, adds two outputs:
  - ray_count, 32 bits: increments on each ray completion, including dropped rays;
  - hit_count, 32 bits: increments on each completion with out_hit=1.
  Both wrap and reset to 0. When the macro is undefined, these ports and their logic are absent.

Verification
REQ-032 Single-triangle ray: in_valid=1, in_last=1, in_hit=1, t=32'h40000000 (2.0), sid=7 -> next cycle out_valid=1, out_sid=7, out_hit=1, out_t=32'h40000000, out_tri_idx=0.
REQ-033 Three-triangle ray with t = 3.0, 1.0, 1.0 (all hits) -> out_t=32'h3F800000 (1.0), out_tri_idx=1 (tie keeps the earlier triangle).
REQ-034 Disqualified hits: t = -1.0 (32'hBF800000), 0, 32'h7FC00000 (NaN), each with in_hit=1 -> out_hit=0, out_t=0, out_tri_idx=0.
REQ-035 FIFO_DEPTH=2 with out_ready=0 and three single-triangle rays -> two entries held and overflow=1; the third ray is absent after draining; a fourth ray pushed in a cycle where out_ready=1 while full is kept and overflow stays unchanged.
REQ-036 Mid-ray reset: rst pulse after 2 of 4 triangles -> all outputs 0 asynchronously; a fresh single-triangle ray afterward produces a correct result at out_tri_idx=0.
